// File: rtl/display_scan_ctrl.sv
// Six-digit multiplexed 7-segment scan controller with blanking, blink, leading-zero
// suppression and frame-aligned shadow register updates.
module display_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] time_in,
  input  logic        upd,
  output logic        upd_ack,
  input  logic [5:0]  blink_en,
  input  logic        blink,
  input  logic        lz_blank,
  input  logic        colon,
  output logic [3:0]  bcd,
  output logic [5:0]  an,
  output logic        dp
);

  localparam int unsigned CntMax = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int unsigned CW     = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CW-1:0] OnLast    = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BlankLast = CW'(BLANK_CYC - 1);

  typedef enum logic {StBlank, StOn} state_e;

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [23:0]   shadow_q, shadow_d;
  logic          ack_d;
  logic [3:0]    digit;
  logic [5:0]    sel;
  logic          suppress;
  logic [5:0]    an_d;
  logic [3:0]    bcd_d;
  logic          dp_d;

  // Phase sequencing; the shadow register only loads at the idx5 ON-to-BLANK edge.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + 1'b1;
    shadow_d = shadow_q;
    ack_d    = 1'b0;
    case (state_q)
      StBlank: begin
        if (cnt_q == BlankLast) begin
          state_d = StOn;
          cnt_d   = '0;
        end
      end
      StOn: begin
        if (cnt_q == OnLast) begin
          state_d = StBlank;
          cnt_d   = '0;
          if (idx_q >= 3'd5) begin
            idx_d = 3'd0;
            if (upd) begin
              shadow_d = time_in;
              ack_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
    endcase
  end

  always_comb begin
    digit = 4'h0;
    case (idx_d)
      3'd0: digit = shadow_d[3:0];
      3'd1: digit = shadow_d[7:4];
      3'd2: digit = shadow_d[11:8];
      3'd3: digit = shadow_d[15:12];
      3'd4: digit = shadow_d[19:16];
      3'd5: digit = shadow_d[23:20];
      default: digit = 4'h0;
    endcase
  end

  // Outputs are registered from next-state so they line up with the cycle's state and idx.
  always_comb begin
    sel      = 6'b000001 << idx_d;
    suppress = (|(blink_en & sel) && blink)
            || (lz_blank && (idx_d == 3'd5) && (digit == 4'h0))
            || (digit > 4'd9);
    an_d  = 6'b111111;
    dp_d  = 1'b0;
    bcd_d = bcd;
    if (state_d == StOn) begin
      bcd_d = digit;
      dp_d  = colon && ((idx_d == 3'd2) || (idx_d == 3'd4));
      if (!suppress) begin
        an_d = ~sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StBlank;
      idx_q    <= 3'd0;
      cnt_q    <= '0;
      shadow_q <= 24'h000000;
      upd_ack  <= 1'b0;
      an       <= 6'b111111;
      bcd      <= 4'h0;
      dp       <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      upd_ack  <= ack_d;
      an       <= an_d;
      bcd      <= bcd_d;
      dp       <= dp_d;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with SCAN_DIV=4, BLANK_CYC=1 (30-cycle frame).
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] time_in;
  logic        upd;
  logic        upd_ack;
  logic [5:0]  blink_en;
  logic        blink;
  logic        lz_blank;
  logic        colon;
  logic [3:0]  bcd;
  logic [5:0]  an;
  logic        dp;

  int checks   = 0;
  int failures = 0;
  int ec       = 0;

  display_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYC(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .time_in  (time_in),
    .upd      (upd),
    .upd_ack  (upd_ack),
    .blink_en (blink_en),
    .blink    (blink),
    .lz_blank (lz_blank),
    .colon    (colon),
    .bcd      (bcd),
    .an       (an),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    ec++;
  endtask

  task automatic go_to(input int e);
    while (ec < e) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, ec);
    end
  endtask

  // ON phase of digit k in a frame starting at edge b spans edges b+5k+1 .. b+5k+4.
  initial begin
    reset = 1'b1; time_in = 24'h0; upd = 1'b0; blink_en = 6'h0;
    blink = 1'b0; lz_blank = 1'b0; colon = 1'b0;
    repeat (3) tick();
    check("rst_an", 32'(an), 32'h3f);
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_dp", 32'(dp), 32'h0);
    check("rst_ack", 32'(upd_ack), 32'h0);
    reset = 1'b0;
    ec = 0;

    go_to(1);  check("f0_idx0_an", 32'(an), 32'h3e); check("f0_idx0_bcd", 32'(bcd), 32'h0);
    go_to(4);  check("f0_idx0_last", 32'(an), 32'h3e);
    go_to(5);  check("f0_blank1", 32'(an), 32'h3f);
    go_to(6);  check("f0_idx1_an", 32'(an), 32'h3d);
    time_in = 24'h123456; upd = 1'b1;
    go_to(26); check("f0_idx5_an", 32'(an), 32'h1f); check("f0_idx5_old", 32'(bcd), 32'h0);
    go_to(29); check("f0_noack", 32'(upd_ack), 32'h0);
    go_to(30); check("f0_ack", 32'(upd_ack), 32'h1); check("f0_bnd_an", 32'(an), 32'h3f);
    upd = 1'b0;
    go_to(31); check("f1_ack_drop", 32'(upd_ack), 32'h0);
    for (int k = 0; k < 6; k++) begin
      go_to(31 + 5 * k);
      check("f1_bcd", 32'(bcd), 32'(6 - k));
      check("f1_an", 32'(~(6'b000001 << k)), 32'(an) ^ 32'hffffffc0);
      check("f1_dp", 32'(dp), 32'h0);
    end
    go_to(60); check("f2_noack", 32'(upd_ack), 32'h0);

    go_to(70); time_in = 24'h093015; upd = 1'b1;
    go_to(90); check("f3_ack", 32'(upd_ack), 32'h1);
    upd = 1'b0; lz_blank = 1'b1; colon = 1'b1;
    go_to(91);  check("lz_idx0_an", 32'(an), 32'h3e); check("lz_idx0_bcd", 32'(bcd), 32'h5);
    check("lz_idx0_dp", 32'(dp), 32'h0);
    go_to(101); check("lz_idx2_an", 32'(an), 32'h3b); check("lz_idx2_dp", 32'(dp), 32'h1);
    go_to(110); check("lz_blank_dp", 32'(dp), 32'h0); check("lz_blank_an", 32'(an), 32'h3f);
    go_to(111); check("lz_idx4_an", 32'(an), 32'h2f); check("lz_idx4_bcd", 32'(bcd), 32'h9);
    check("lz_idx4_dp", 32'(dp), 32'h1);
    go_to(116); check("lz_idx5_an", 32'(an), 32'h3f); check("lz_idx5_dp", 32'(dp), 32'h0);
    time_in = 24'h21C543; upd = 1'b1;
    go_to(120); check("f4_ack", 32'(upd_ack), 32'h1);
    upd = 1'b0; lz_blank = 1'b0; colon = 1'b0;
    go_to(121); check("bad_idx0_bcd", 32'(bcd), 32'h3);
    go_to(131); check("bad_idx2_an", 32'(an), 32'h3b); check("bad_idx2_bcd", 32'(bcd), 32'h5);
    go_to(136); check("bad_idx3_an", 32'(an), 32'h3f);
    go_to(139); check("bad_idx3_end", 32'(an), 32'h3f);
    go_to(141); check("bad_idx4_an", 32'(an), 32'h2f); check("bad_idx4_bcd", 32'(bcd), 32'h1);

    go_to(149); blink_en = 6'b000011;
    go_to(150); blink = 1'b1;
    go_to(151); check("blk_idx0_dark", 32'(an), 32'h3f);
    go_to(152); blink = 1'b0;
    go_to(153); check("blk_idx0_lit", 32'(an), 32'h3e); check("blk_idx0_bcd", 32'(bcd), 32'h3);
    go_to(156); check("blk_idx1_lit", 32'(an), 32'h3d);
    blink = 1'b1;
    go_to(157); check("blk_idx1_dark", 32'(an), 32'h3f);
    go_to(161); check("blk_idx2_lit", 32'(an), 32'h3b);
    blink = 1'b0; blink_en = 6'h0;
    time_in = 24'h654321; upd = 1'b1;

    go_to(180); check("f6_ack", 32'(upd_ack), 32'h1);
    reset = 1'b1;
    go_to(181); check("rst2_ack", 32'(upd_ack), 32'h0); check("rst2_an", 32'(an), 32'h3f);
    check("rst2_bcd", 32'(bcd), 32'h0);
    go_to(182); reset = 1'b0;
    go_to(183); check("rst2_shadow0", 32'(bcd), 32'h0); check("rst2_idx0_an", 32'(an), 32'h3e);
    go_to(200); check("rst2_noack", 32'(upd_ack), 32'h0);
    go_to(212); check("rst2_reack", 32'(upd_ack), 32'h1);
    upd = 1'b0;
    go_to(213); check("rc_idx0_bcd", 32'(bcd), 32'h1); check("rc_idx0_an", 32'(an), 32'h3e);
    go_to(238); check("rc_idx5_bcd", 32'(bcd), 32'h6); check("rc_idx5_an", 32'(an), 32'h1f);
    go_to(242); check("rc_noack", 32'(upd_ack), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: number of clk cycles each digit is lit (ON phase), legal range >= 2.
REQ-002 SHALL have parameter BLANK_CYC, default 2: number of clk cycles of anti-ghost blanking before each digit, legal range >= 1.
REQ-003 SHALL have port clk, input, 1: the single system clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port time_in, input, 24: six BCD digits {H10,H1,M10,M1,S10,S1}; digit d occupies bits [4d+3:4d], so S1 is d=0 and H10 is d=5.
REQ-006 SHALL have port upd, input, 1: update request; the requester holds it high until upd_ack.
REQ-007 SHALL have port upd_ack, output, 1: one-cycle pulse when time_in has been captured.
REQ-008 SHALL have port blink_en, input, 6: per-digit blink mask.
REQ-009 SHALL have port blink, input, 1: blink phase; 1 means blanking is allowed.
REQ-010 SHALL have port lz_blank, input, 1: blank H10 when it is zero.
REQ-011 SHALL have port colon, input, 1: colon enable.
REQ-012 SHALL have port bcd, output, 4: digit code driven to the external 7-segment decoder input.
REQ-013 SHALL have port an, output, 6: active-low one-hot digit enable; bit d selects digit d.
REQ-014 SHALL have port dp, output, 1: active-high decimal-point/colon segment.

Function
REQ-015 SHALL hold a 24-bit shadow register; displayed values come only from the shadow register, never directly from time_in.
REQ-016 SHALL implement a two-state FSM.
- BLANK: lasts BLANK_CYC cycles, then goes to ON.
- ON: lasts SCAN_DIV cycles, then goes to BLANK with idx advanced.
REQ-017 SHALL use a 3-bit digit index idx that counts 0,1,2,3,4,5 and wraps from 5 to 0; values 6 and 7 SHALL never occur.
REQ-018 SHALL register all outputs; an, bcd and dp SHALL reflect the state and idx of the current cycle, with no combinational path from inputs to outputs.
REQ-019 SHALL drive an=6'b111111 and dp=0 in BLANK, with bcd holding its last value.
REQ-020 SHALL, in ON, drive bcd=shadow digit idx and an=~(1<<idx), unless that digit is suppressed (REQ-021).
REQ-021 SHALL suppress a digit by driving an=6'b111111 for its whole ON phase when any of these holds:
- blink_en[idx]=1 and blink=1;
- lz_blank=1, idx=5 and shadow H10=0;
- the shadow digit value > 9.
REQ-022 SHALL evaluate blink and lz_blank every cycle in ON, so a blink edge takes effect on the next cycle.
REQ-023 SHALL drive dp=1 in ON when colon=1 and idx is 2 or 4, and dp=0 otherwise; digit suppression SHALL NOT affect dp.
REQ-024 SHALL sample upd only at the frame boundary, i.e. the ON-to-BLANK transition leaving idx=5.
- If upd=1 there: shadow<=time_in and upd_ack=1 for exactly that one cycle.
- Otherwise the shadow register is unchanged.
REQ-025 SHALL recapture time_in at the next frame boundary if upd is still high; this is legal and produces a second ack.
REQ-026 SHALL never change the shadow register mid-frame, so one scan never mixes old and new digits.
REQ-027 SHALL have frame period 6*(BLANK_CYC+SCAN_DIV) cycles and worst-case update latency one frame plus one cycle.

Reset
REQ-028 SHALL, on reset=1 at a clock edge, set:
- state=BLANK, idx=0, phase counter=0;
- shadow=24'h000000;
- an=6'b111111, bcd=4'h0, dp=0, upd_ack=0.
REQ-029 SHALL give reset priority over all other activity; reset asserted mid-frame or during an upd_ack cycle SHALL abort that activity and drop the ack.
REQ-030 SHALL leave the first ON phase after reset release to begin after BLANK_CYC cycles, with idx=0.

Verification (SCAN_DIV=4, BLANK_CYC=1, frame=30 cycles)
REQ-031 Reset release, no upd -> an=111111 for 1 cycle, then an=111110 and bcd=0 for 4 cycles, then 111111 for 1, then 111101 for 4 ...; idx wraps to 0 after cycle 30.
REQ-032 upd=1 with time_in=24'h123456 mid-frame -> no change until the frame boundary, then upd_ack pulses for one cycle; the next frame shows bcd 6,5,4,3,2,1 on idx 0..5.
REQ-033 shadow=24'h093015, lz_blank=1, colon=1 -> idx5 an=111111; idx4 bcd=9 with dp=1; idx2 dp=1; all other digits lit with dp=0.
REQ-034 blink_en=6'b000011, blink toggling every 8 cycles -> idx0 and idx1 dark only while blink=1; other digits unaffected.
REQ-035 shadow digit 4'hC at idx3 -> an=111111 during idx3 ON; neighbouring digits normal.
REQ-036 reset asserted at the upd_ack cycle -> upd_ack=0 next cycle and shadow=0; with upd still high, recapture occurs at the first frame boundary after release.
